// File: rtl/liberty_pruner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// liberty_pruner : removes prune-colour stones whose group has no liberty,
//                  found by iterative flood fill from liberty-adjacent stones.
// Revision: 1.0
// ----------------------------------------------------------------------------
module liberty_pruner #(
    parameter int N     = 9,
    parameter int CNT_W = $clog2(N*N+1)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic [1:0]           prune_color_in,
    input  logic [2*N*N-1:0]     board_in,
    output logic                 ready_out,
    output logic                 done_out,
    output logic [2*N*N-1:0]     pruned_board_out,
    output logic [CNT_W-1:0]     capture_count_out,
    output logic [CNT_W-1:0]     iter_count_out
);

    localparam int               c_cells    = N*N;
    localparam logic [CNT_W-1:0] c_iter_max = CNT_W'(N*N);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEED   = 2'd1,
        S_PROP   = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t               r_state;
    logic [2*N*N-1:0]     r_board;
    logic [1:0]           r_color;
    logic [c_cells-1:0]   r_alive;
    logic [CNT_W-1:0]     r_iter;
    logic                 r_done;
    logic [2*N*N-1:0]     r_pruned;
    logic [CNT_W-1:0]     r_capture;
    logic [CNT_W-1:0]     r_iter_out;

    logic                 w_color_ok;
    logic [c_cells-1:0]   w_match;
    logic [c_cells-1:0]   w_empty;
    logic [c_cells-1:0]   w_seed;
    logic [c_cells-1:0]   w_next;
    logic [c_cells-1:0]   w_removed;
    logic [2*N*N-1:0]     w_pruned;
    logic [CNT_W-1:0]     w_pop;

    // Colours 00/11 match nothing, so the whole board passes through untouched.
    assign w_color_ok = (r_color == 2'b01) || (r_color == 2'b10);

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            localparam int I = r*N + c;
            logic [3:0] w_e;
            logic [3:0] w_a;

            assign w_match[I] = w_color_ok && (r_board[2*I+:2] == r_color);
            assign w_empty[I] = (r_board[2*I+:2] == 2'b00) || (r_board[2*I+:2] == 2'b11);

            // Off-board neighbours contribute neither liberty nor life.
            if (r > 0) begin : g_up
                assign w_e[0] = w_empty[I-N];
                assign w_a[0] = r_alive[I-N];
            end else begin : g_up_edge
                assign w_e[0] = 1'b0;
                assign w_a[0] = 1'b0;
            end
            if (r < N-1) begin : g_dn
                assign w_e[1] = w_empty[I+N];
                assign w_a[1] = r_alive[I+N];
            end else begin : g_dn_edge
                assign w_e[1] = 1'b0;
                assign w_a[1] = 1'b0;
            end
            if (c > 0) begin : g_lf
                assign w_e[2] = w_empty[I-1];
                assign w_a[2] = r_alive[I-1];
            end else begin : g_lf_edge
                assign w_e[2] = 1'b0;
                assign w_a[2] = 1'b0;
            end
            if (c < N-1) begin : g_rt
                assign w_e[3] = w_empty[I+1];
                assign w_a[3] = r_alive[I+1];
            end else begin : g_rt_edge
                assign w_e[3] = 1'b0;
                assign w_a[3] = 1'b0;
            end

            assign w_seed[I]          = w_match[I] & (|w_e);
            assign w_next[I]          = r_alive[I] | (w_match[I] & (|w_a));
            assign w_removed[I]       = w_match[I] & ~r_alive[I];
            assign w_pruned[2*I+:2]   = w_removed[I] ? 2'b00 : r_board[2*I+:2];
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < c_cells; i++) begin
            w_pop = w_pop + CNT_W'(w_removed[i]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_board    <= '0;
            r_color    <= 2'b00;
            r_alive    <= '0;
            r_iter     <= '0;
            r_done     <= 1'b0;
            r_pruned   <= '0;
            r_capture  <= '0;
            r_iter_out <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_board <= board_in;
                        r_color <= prune_color_in;
                        r_state <= S_SEED;
                    end
                end
                S_SEED: begin
                    r_alive <= w_seed;
                    r_iter  <= '0;
                    r_state <= S_PROP;
                end
                S_PROP: begin
                    if ((w_next == r_alive) || (r_iter == c_iter_max)) begin
                        r_state <= S_OUTPUT;
                    end else begin
                        r_alive <= w_next;
                        r_iter  <= r_iter + CNT_W'(1);
                    end
                end
                S_OUTPUT: begin
                    r_pruned   <= w_pruned;
                    r_capture  <= w_pop;
                    r_iter_out <= r_iter;
                    r_done     <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Each PROP step grows the alive set by at least one cell, so N*N is never hit.
    a_iter_bound: assert property (@(posedge clk_in) disable iff (rst_in)
        (r_state == S_PROP) |-> (r_iter < c_iter_max));

    assign ready_out         = (r_state == S_IDLE);
    assign done_out          = r_done;
    assign pruned_board_out  = r_pruned;
    assign capture_count_out = r_capture;
    assign iter_count_out    = r_iter_out;

endmodule
`default_nettype wire

// File: tb/tb_liberty_pruner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_liberty_pruner : directed scoreboard bench for 9x9 and 19x19 builds.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_liberty_pruner;

    localparam int N9   = 9;
    localparam int N19  = 19;
    localparam int W9   = 2*N9*N9;
    localparam int W19  = 2*N19*N19;
    localparam int CW9  = $clog2(N9*N9+1);
    localparam int CW19 = $clog2(N19*N19+1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            s9, s19;
    logic [1:0]      col9, col19;
    logic [W9-1:0]   bin9;
    logic [W19-1:0]  bin19;
    logic            rdy9, done9, rdy19, done19;
    logic [W9-1:0]   pb9;
    logic [W19-1:0]  pb19;
    logic [CW9-1:0]  cap9, it9;
    logic [CW19-1:0] cap19, it19;

    liberty_pruner #(.N(N9)) u_dut9 (
        .clk_in(clk), .rst_in(rst), .start_in(s9), .prune_color_in(col9),
        .board_in(bin9), .ready_out(rdy9), .done_out(done9),
        .pruned_board_out(pb9), .capture_count_out(cap9), .iter_count_out(it9)
    );

    liberty_pruner #(.N(N19)) u_dut19 (
        .clk_in(clk), .rst_in(rst), .start_in(s19), .prune_color_in(col19),
        .board_in(bin19), .ready_out(rdy19), .done_out(done19),
        .pruned_board_out(pb19), .capture_count_out(cap19), .iter_count_out(it19)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int dn9   = 0, dn19 = 0;
    int pu9   = 0, pu19 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W19-1:0] board;
        int             cap;
        int             iter;
        int             done_cyc;
        string          name;
    } exp_t;

    exp_t q9[$];
    exp_t q19[$];
    exp_t m9, m19;

    task automatic chk(input string name, input logic [W19-1:0] act, input logic [W19-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done9 === 1'b1) begin
            dn9++;
            if (q9.size() == 0) begin
                chk("dut9 unexpected done", W19'(done9), '0);
            end else begin
                m9 = q9.pop_front();
                chk({m9.name, " board"},   W19'(pb9),  m9.board);
                chk({m9.name, " capture"}, W19'(cap9), W19'(m9.cap));
                chk({m9.name, " iter"},    W19'(it9),  W19'(m9.iter));
                chk({m9.name, " latency"}, W19'(cyc),  W19'(m9.done_cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (done19 === 1'b1) begin
            dn19++;
            if (q19.size() == 0) begin
                chk("dut19 unexpected done", W19'(done19), '0);
            end else begin
                m19 = q19.pop_front();
                chk({m19.name, " board"},   pb19,        m19.board);
                chk({m19.name, " capture"}, W19'(cap19), W19'(m19.cap));
                chk({m19.name, " iter"},    W19'(it19),  W19'(m19.iter));
                chk({m19.name, " latency"}, W19'(cyc),   W19'(m19.done_cyc));
            end
        end
    end

    function automatic logic [W19-1:0] setc(input logic [W19-1:0] bb, input int n,
                                            input int r, input int c, input logic [1:0] v);
        bb[2*(r*n+c)+:2] = v;
        return bb;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input bit big, input logic [W19-1:0] b, input logic [1:0] col,
                         input bit push, input int cap, input int iter, input int lat,
                         input logic [W19-1:0] eb, input string name);
        exp_t e;
        int   n = 0;
        while (!(big ? rdy19 : rdy9) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk({name, " ready timeout"}, W19'(big ? rdy19 : rdy9), W19'(1));
            return;
        end
        if (push) begin
            e.board    = eb;
            e.cap      = cap;
            e.iter     = iter;
            e.done_cyc = cyc + 1 + lat;
            e.name     = name;
            if (big) begin q19.push_back(e); pu19++; end
            else     begin q9.push_back(e);  pu9++;  end
        end
        if (big) begin bin19 = b; col19 = col; s19 = 1'b1; end
        else     begin bin9 = b[W9-1:0]; col9 = col; s9 = 1'b1; end
        @(negedge clk);
        s9  = 1'b0;
        s19 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q9.size() != 0 || q19.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    logic [W19-1:0] b, e, chain_lib, chain_dead, chain_dead_exp, white9, ring, ring_exp, ring2;
    int seen;

    initial begin
        rst = 1'b1; s9 = 1'b0; s19 = 1'b0;
        col9 = 2'b00; col19 = 2'b00; bin9 = '0; bin19 = '0;
        repeat (3) @(negedge clk);
        chk("reset ready9",   W19'(rdy9),  W19'(1));
        chk("reset done9",    W19'(done9), '0);
        chk("reset board9",   W19'(pb9),   '0);
        chk("reset capture9", W19'(cap9),  '0);
        chk("reset iter9",    W19'(it9),   '0);
        chk("reset ready19",  W19'(rdy19), W19'(1));
        chk("reset board19",  pb19,        '0);
        rst = 1'b0;
        @(negedge clk);

        // Single black stone in the corner, surrounded by white.
        b = '0;
        b = setc(b, N9, 0, 0, 2'b01);
        b = setc(b, N9, 0, 1, 2'b10);
        b = setc(b, N9, 1, 0, 2'b10);
        e = setc(b, N9, 0, 0, 2'b00);
        issue(0, b, 2'b01, 1, 1, 0, 3, e, "t1 corner");
        issue(0, b, 2'b00, 1, 0, 0, 3, b, "t4 col00");
        issue(0, b, 2'b11, 1, 0, 0, 3, b, "t4 col11");

        white9 = '0;
        for (int i = 0; i < N9*N9; i++) white9[2*i+:2] = 2'b10;
        issue(0, '0,     2'b10, 1, 0,  0, 3, '0, "t3 empty");
        issue(0, white9, 2'b10, 1, 81, 0, 3, '0, "t3 allwhite");

        // Serpentine black chain of 20 with its only liberty below the tail at (4,0).
        chain_lib = white9;
        chain_dead_exp = white9;
        for (int c = 0; c < N9; c++) begin
            chain_lib = setc(chain_lib, N9, 0, c, 2'b01);
            chain_lib = setc(chain_lib, N9, 2, c, 2'b01);
            chain_dead_exp = setc(chain_dead_exp, N9, 0, c, 2'b00);
            chain_dead_exp = setc(chain_dead_exp, N9, 2, c, 2'b00);
        end
        chain_lib = setc(chain_lib, N9, 1, 8, 2'b01);
        chain_lib = setc(chain_lib, N9, 3, 0, 2'b01);
        chain_dead_exp = setc(chain_dead_exp, N9, 1, 8, 2'b00);
        chain_dead_exp = setc(chain_dead_exp, N9, 3, 0, 2'b00);
        chain_lib = setc(chain_lib, N9, 4, 0, 2'b00);
        chain_dead = setc(chain_lib, N9, 4, 0, 2'b10);
        chain_dead_exp = setc(chain_dead_exp, N9, 4, 0, 2'b10);
        issue(0, chain_lib,  2'b01, 1, 0,  19, 22, chain_lib,      "t2 chain live");
        issue(0, chain_dead, 2'b01, 1, 20, 0,  3,  chain_dead_exp, "t2 chain dead");

        // Spurious start while busy must be dropped.
        issue(0, chain_lib, 2'b01, 1, 0, 19, 22, chain_lib, "t5 busy start");
        repeat (3) @(negedge clk);
        bin9 = white9[W9-1:0]; col9 = 2'b10; s9 = 1'b1;
        @(negedge clk);
        s9 = 1'b0;
        drain();

        // Reset during PROP discards the job.
        issue(0, chain_lib, 2'b01, 0, 0, 0, 0, '0, "t5 reset job");
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5 rst ready",   W19'(rdy9),  W19'(1));
        chk("t5 rst done",    W19'(done9), '0);
        chk("t5 rst board",   W19'(pb9),   '0);
        chk("t5 rst capture", W19'(cap9),  '0);
        chk("t5 rst iter",    W19'(it9),   '0);
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done9 === 1'b1) seen++;
        end
        chk("t5 no done after reset", W19'(seen), '0);

        // 19x19: white ring around a 3x3 black block, then back-to-back with a hole.
        ring = '0;
        for (int r = 7; r <= 11; r++)
            for (int c = 7; c <= 11; c++)
                if (r == 7 || r == 11 || c == 7 || c == 11) ring = setc(ring, N19, r, c, 2'b10);
        ring_exp = ring;
        for (int r = 8; r <= 10; r++)
            for (int c = 8; c <= 10; c++) ring = setc(ring, N19, r, c, 2'b01);
        ring2 = setc(ring, N19, 7, 9, 2'b00);
        issue(1, ring,  2'b01, 1, 9, 0, 3, ring_exp, "t6 ring");
        issue(1, ring2, 2'b01, 1, 0, 3, 6, ring2,    "t6 b2b hole");

        drain();
        repeat (3) @(negedge clk);
        chk("final q9 empty",  W19'(q9.size()),  '0);
        chk("final q19 empty", W19'(q19.size()), '0);
        chk("dut9 done count",  W19'(dn9),  W19'(pu9));
        chk("dut19 done count", W19'(dn19), W19'(pu19));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
